// File: rtl/multi_mode_ff_bank.sv
// -----------------------------------------------------------------------------
// multi_mode_ff_bank
//
// Bank of WIDTH independent single-bit storage channels. All channels share one
// mode select and behave as SR, JK, D or T flip-flops. Each channel reports a
// one-cycle change pulse. In SR mode, S=R=1 is resolved by SR_POLICY and is
// recorded as an illegal event.
//
// Parameters:
//   WIDTH      number of channels (1..64)
//   RESET_VAL  value loaded into q on reset
//   SR_POLICY  SR response to S=R=1: 0 hold, 1 set wins, 2 reset wins
//   CNT_W      width of the saturating illegal-event counter
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   en            clock enable; state updates only when 1
//   mode          00 SR, 01 JK, 10 D, 11 T (shared by all channels)
//   a             S / J / D / T input per channel
//   b             R / K input per channel (unused in D and T modes)
//   clr_stat      synchronous clear of illegal_flag and illegal_cnt
//   q             stored state
//   q_bar         ~q, combinational from q
//   chg           registered pulse: the channel's q changed at the last edge
//   illegal_flag  sticky per-channel SR S=R=1 indicator
//   illegal_cnt   saturating count of cycles with any illegal channel
// -----------------------------------------------------------------------------
module multi_mode_ff_bank #(
    parameter int unsigned             WIDTH     = 8,
    parameter logic [WIDTH-1:0]        RESET_VAL = '0,
    parameter int unsigned             SR_POLICY = 0,
    parameter int unsigned             CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_stat,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] chg,
    output logic [WIDTH-1:0] illegal_flag,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] chg_q, chg_d;
    logic [WIDTH-1:0] flag_q, flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] illegal_vec;
    logic             any_illegal;

    // Per-channel next state as if enabled. The enable is applied afterwards.
    always_comb begin
        next_q = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode)
                MODE_SR: begin
                    case ({a[i], b[i]})
                        2'b10:   next_q[i] = 1'b1;
                        2'b01:   next_q[i] = 1'b0;
                        2'b11: begin
                            if (SR_POLICY == 1)      next_q[i] = 1'b1;
                            else if (SR_POLICY == 2) next_q[i] = 1'b0;
                            else                     next_q[i] = q_q[i];
                        end
                        default: next_q[i] = q_q[i];
                    endcase
                end
                MODE_JK: begin
                    case ({a[i], b[i]})
                        2'b10:   next_q[i] = 1'b1;
                        2'b01:   next_q[i] = 1'b0;
                        2'b11:   next_q[i] = ~q_q[i];
                        default: next_q[i] = q_q[i];
                    endcase
                end
                MODE_D:  next_q[i] = a[i];
                MODE_T:  next_q[i] = a[i] ? ~q_q[i] : q_q[i];
                default: next_q[i] = q_q[i];
            endcase
        end
    end

    // An illegal event is flagged independently of how SR_POLICY resolves it.
    always_comb begin
        illegal_vec = '0;
        if (en && (mode == MODE_SR)) begin
            illegal_vec = a & b;
        end
        any_illegal = |illegal_vec;
    end

    always_comb begin
        q_d   = en ? next_q : q_q;
        chg_d = en ? (next_q ^ q_q) : '0;

        // A new event in the same cycle as a clear takes priority over the clear.
        flag_d = clr_stat ? illegal_vec : (flag_q | illegal_vec);

        cnt_d = cnt_q;
        if (clr_stat) begin
            cnt_d = any_illegal ? CNT_W'(1) : '0;
        end else if (any_illegal && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= RESET_VAL;
            chg_q  <= '0;
            flag_q <= '0;
            cnt_q  <= '0;
        end else begin
            q_q    <= q_d;
            chg_q  <= chg_d;
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q            = q_q;
    assign q_bar        = ~q_q;
    assign chg          = chg_q;
    assign illegal_flag = flag_q;
    assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// -----------------------------------------------------------------------------
// tb_multi_mode_ff_bank
//
// Directed bench for multi_mode_ff_bank. Three instances (one per SR_POLICY)
// share all inputs. Each uses WIDTH=4, RESET_VAL=4'b1010 and CNT_W=2.
// -----------------------------------------------------------------------------
module tb_multi_mode_ff_bank;

    localparam int W = 4;
    localparam int C = 2;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         clr_stat;

    logic [W-1:0] p0_q, p0_qb, p0_chg, p0_flag;
    logic [C-1:0] p0_cnt;
    logic [W-1:0] p1_q, p1_qb, p1_chg, p1_flag;
    logic [C-1:0] p1_cnt;
    logic [W-1:0] p2_q, p2_qb, p2_chg, p2_flag;
    logic [C-1:0] p2_cnt;

    int tests_run;
    int tests_failed;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    multi_mode_ff_bank #(.WIDTH(W), .RESET_VAL(4'b1010), .SR_POLICY(0), .CNT_W(C)) u_p0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .clr_stat(clr_stat),
        .q(p0_q), .q_bar(p0_qb), .chg(p0_chg), .illegal_flag(p0_flag), .illegal_cnt(p0_cnt)
    );

    multi_mode_ff_bank #(.WIDTH(W), .RESET_VAL(4'b1010), .SR_POLICY(1), .CNT_W(C)) u_p1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .clr_stat(clr_stat),
        .q(p1_q), .q_bar(p1_qb), .chg(p1_chg), .illegal_flag(p1_flag), .illegal_cnt(p1_cnt)
    );

    multi_mode_ff_bank #(.WIDTH(W), .RESET_VAL(4'b1010), .SR_POLICY(2), .CNT_W(C)) u_p2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .clr_stat(clr_stat),
        .q(p2_q), .q_bar(p2_qb), .chg(p2_chg), .illegal_flag(p2_flag), .illegal_cnt(p2_cnt)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n    = 1'b1;
        en       = 1'b0;
        mode     = 2'b00;
        a        = '0;
        b        = '0;
        clr_stat = 1'b0;

        // Reset asserted mid-cycle, before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        check("rst_q",     64'(p0_q),    64'hA);
        check("rst_qbar",  64'(p0_qb),   64'h5);
        check("rst_chg",   64'(p0_chg),  64'h0);
        check("rst_cnt",   64'(p0_cnt),  64'h0);
        check("rst_flag",  64'(p0_flag), 64'h0);

        step();
        step();
        rst_n = 1'b1;

        // D load of 0000 from the reset value 1010.
        mode = 2'b10; a = 4'b0000; en = 1'b1;
        step();
        check("dload_q",   64'(p0_q),   64'h0);
        check("dload_chg", 64'(p0_chg), 64'hA);

        // SR with one set, one reset, one S=R=1 channel and one hold channel.
        mode = 2'b00; a = 4'b0011; b = 4'b0101;
        step();
        check("sr_p0_q",    64'(p0_q),    64'h2);
        check("sr_p1_q",    64'(p1_q),    64'h3);
        check("sr_p2_q",    64'(p2_q),    64'h2);
        check("sr_p0_flag", 64'(p0_flag), 64'h1);
        check("sr_p1_flag", 64'(p1_flag), 64'h1);
        check("sr_p2_flag", 64'(p2_flag), 64'h1);
        check("sr_p0_cnt",  64'(p0_cnt),  64'h1);
        check("sr_p0_chg",  64'(p0_chg),  64'h2);
        check("sr_p1_qbar", 64'(p1_qb),   64'hC);

        // Clear alone while disabled: q holds, stats cleared.
        en = 1'b0; clr_stat = 1'b1; a = '0; b = '0;
        step();
        check("clr_flag", 64'(p0_flag), 64'h0);
        check("clr_cnt",  64'(p0_cnt),  64'h0);
        check("clr_q",    64'(p0_q),    64'h2);
        check("clr_chg",  64'(p0_chg),  64'h0);

        // Back to 0000 via D.
        clr_stat = 1'b0; en = 1'b1; mode = 2'b10; a = 4'b0000;
        step();
        check("d0_q", 64'(p0_q), 64'h0);

        // JK toggle over three enabled edges.
        mode = 2'b01; a = 4'b1111; b = 4'b1111;
        step();
        check("jk1_q",   64'(p0_q),   64'hF);
        check("jk1_chg", 64'(p0_chg), 64'hF);
        step();
        check("jk2_q",   64'(p0_q),   64'h0);
        check("jk2_chg", 64'(p0_chg), 64'hF);
        step();
        check("jk3_q",   64'(p0_q),   64'hF);
        check("jk3_chg", 64'(p0_chg), 64'hF);
        check("jk_cnt",  64'(p0_cnt), 64'h0);

        // Enable low: hold and no change pulse.
        en = 1'b0;
        step();
        check("hold_q",   64'(p0_q),   64'hF);
        check("hold_chg", 64'(p0_chg), 64'h0);

        // Mode change alone while disabled must not alter q.
        mode = 2'b11; a = 4'b1111; b = 4'b0000;
        step();
        check("mchg_q", 64'(p0_q), 64'hF);

        // T toggle over three enabled edges.
        en = 1'b1;
        step();
        check("t1_q",   64'(p0_q),   64'h0);
        check("t1_chg", 64'(p0_chg), 64'hF);
        step();
        check("t2_q",   64'(p0_q),   64'hF);
        check("t2_chg", 64'(p0_chg), 64'hF);
        step();
        check("t3_q",   64'(p0_q),   64'h0);
        check("t3_chg", 64'(p0_chg), 64'hF);

        // D capture gated by enable.
        mode = 2'b10; a = 4'b1001; en = 1'b0;
        step();
        check("den0_q",   64'(p0_q),   64'h0);
        check("den0_chg", 64'(p0_chg), 64'h0);
        en = 1'b1;
        step();
        check("den1_q",   64'(p0_q),   64'h9);
        check("den1_chg", 64'(p0_chg), 64'h9);
        step();
        check("dsame_chg", 64'(p0_chg), 64'h0);
        a = 4'b1100;
        step();
        check("dpart_q",   64'(p0_q),   64'hC);
        check("dpart_chg", 64'(p0_chg), 64'h5);

        // Counter saturation: five consecutive illegal cycles on channel 0.
        mode = 2'b00; a = 4'b0001; b = 4'b0001;
        step();
        check("sat1", 64'(p0_cnt), 64'h1);
        step();
        check("sat2", 64'(p0_cnt), 64'h2);
        step();
        check("sat3", 64'(p0_cnt), 64'h3);
        step();
        check("sat4", 64'(p0_cnt), 64'h3);
        step();
        check("sat5", 64'(p0_cnt), 64'h3);
        check("sat_p0_q", 64'(p0_q), 64'hC);
        check("sat_p1_q", 64'(p1_q), 64'hD);
        check("sat_p2_q", 64'(p2_q), 64'hC);
        check("sat_flag", 64'(p0_flag), 64'h1);

        // Clear colliding with a new illegal event on channel 2 only.
        clr_stat = 1'b1; a = 4'b0100; b = 4'b0100;
        step();
        check("coll_flag", 64'(p0_flag), 64'h4);
        check("coll_cnt",  64'(p0_cnt),  64'h1);

        // Clear alone.
        a = 4'b0000; b = 4'b0000;
        step();
        check("clr2_flag", 64'(p0_flag), 64'h0);
        check("clr2_cnt",  64'(p0_cnt),  64'h0);

        // S=R=1 with enable low is not an illegal event.
        clr_stat = 1'b0; en = 1'b0; a = 4'b1111; b = 4'b1111;
        step();
        check("noen_flag", 64'(p0_flag), 64'h0);
        check("noen_cnt",  64'(p0_cnt),  64'h0);

        // Reset in the middle of a chg pulse clears it at once.
        en = 1'b1; mode = 2'b10; a = 4'b0011; b = 4'b0000;
        step();
        check("pre_rst_chg", 64'(p0_chg), 64'hF);
        rst_n = 1'b0;
        #1;
        check("mid_rst_chg",  64'(p0_chg), 64'h0);
        check("mid_rst_q",    64'(p0_q),   64'hA);
        check("mid_rst_qbar", 64'(p0_qb),  64'h5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
